// File: rtl/alu_pkg.sv
// Shared opcodes, scheduler FSM states and the round-robin pick helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_NOR   = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_XNOR  = 4'b0110;
    localparam logic [3:0] ALU_NAND  = 4'b0111;
    localparam logic [3:0] ALU_PASSA = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;
    localparam logic [3:0] ALU_ZERO  = 4'b1010;
    localparam logic [3:0] ALU_SLT   = 4'b1011;
    localparam logic [3:0] ALU_SLTU  = 4'b1100;
    localparam logic [3:0] ALU_SLL   = 4'b1101;
    localparam logic [3:0] ALU_SRL   = 4'b1110;
    localparam logic [3:0] ALU_SRA   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // First requester with valid set, scanning upward from ptr+1 with wrap.
    // Returns ptr unchanged when nothing is valid (caller gates on |valid).
    function automatic int unsigned rr_pick(input logic [7:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned nreq);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = (ptr + k) % nreq;
            if (!found && (k <= nreq) && valid[3'(idx)]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/alu.sv
// 64-bit combinational ALU, 16 opcodes. cout is the adder carry for ADD and
// the not-borrow carry (a >= b unsigned) for SUB; zero for every other op.
// Shift amount is the low log2(XLEN) bits of B.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            cout_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN:0]  sum;
    logic [XLEN:0]  diff;
    logic [SHW-1:0] shamt;

    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} + {1'b0, ~b_i} + (XLEN+1)'(1);
    assign shamt = b_i[SHW-1:0];

    // Opcode decode into result and carry-out.
    always_comb begin
        result_o = '0;
        cout_o   = 1'b0;
        case (op_i)
            ALU_ADD:   begin result_o = sum[XLEN-1:0];  cout_o = sum[XLEN];  end
            ALU_SUB:   begin result_o = diff[XLEN-1:0]; cout_o = diff[XLEN]; end
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_NOR:   result_o = ~(a_i | b_i);
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_XNOR:  result_o = ~(a_i ^ b_i);
            ALU_NAND:  result_o = ~(a_i & b_i);
            ALU_PASSA: result_o = a_i;
            ALU_PASSB: result_o = b_i;
            ALU_ZERO:  result_o = '0;
            ALU_SLT:   result_o[0] = ($signed(a_i) < $signed(b_i));
            ALU_SLTU:  result_o[0] = (a_i < b_i);
            ALU_SLL:   result_o = a_i << shamt;
            ALU_SRL:   result_o = a_i >> shamt;
            ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NREQ requesters: operands are
// registered on grant, the ALU runs for one cycle, and the result is held on a
// valid/ready response channel. Flush aborts the in-flight op with no response.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1,
    parameter int unsigned CNTW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [XLEN*NREQ-1:0] req_a,
    input  logic [XLEN*NREQ-1:0] req_b,
    input  logic                 flush,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_cout,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [IDW-1:0]  id_q;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_cout_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic            any_valid;
    logic            grant_en;
    logic            accept;
    logic            rsp_hs;
    logic            exec_done;
    logic [IDW-1:0]  winner;
    logic [3:0]      op_sel;
    logic [XLEN-1:0] a_sel, b_sel;
    logic [XLEN-1:0] alu_res;
    logic            alu_cout;

    // Grant is only offered when the ALU will be free on the next edge;
    // reset and flush both suppress it so req_ready reads 0 during either.
    assign any_valid  = |req_valid;
    assign grant_en   = !rst && !flush &&
                        ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
    assign accept     = grant_en && any_valid;
    assign rsp_hs     = !flush && (state_q == S_RESP) && rsp_ready;
    assign exec_done  = !flush && (state_q == S_EXEC);
    assign winner     = IDW'(rr_pick(8'(req_valid), 32'(rr_ptr_q), NREQ));
    assign op_count_d = op_count_q + CNTW'(1);

    // Winner one-hot grant and operand mux.
    always_comb begin
        req_ready = '0;
        op_sel    = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                req_ready[i] = accept;
                op_sel       = req_op[4*i +: 4];
                a_sel        = req_a[XLEN*i +: XLEN];
                b_sel        = req_b[XLEN*i +: XLEN];
            end
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        if (flush) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (any_valid) state_d = S_EXEC;
                S_EXEC: begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end
                S_RESP: if (rsp_ready) begin
                    state_d     = any_valid ? S_EXEC : S_IDLE;
                    rsp_valid_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    alu #(.XLEN(XLEN)) u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .cout_o   (alu_cout)
    );

    // FSM state and response valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Operand capture and round-robin pointer update on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= IDW'(NREQ - 1);
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
        end else if (accept) begin
            rr_ptr_q <= winner;
            op_q     <= op_sel;
            a_q      <= a_sel;
            b_q      <= b_sel;
            id_q     <= winner;
        end
    end

    // Result capture at the end of the single EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
        end else if (exec_done) begin
            rsp_data_q <= alu_res;
            rsp_cout_q <= alu_cout;
            rsp_id_q   <= id_q;
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (rsp_hs) begin
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: ALU vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_rr_scheduler;
    import alu_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;
    localparam int unsigned CNTW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [4*NREQ-1:0]    req_op;
    logic [XLEN*NREQ-1:0] req_a;
    logic [XLEN*NREQ-1:0] req_b;
    logic                 flush;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [XLEN-1:0]      rsp_data;
    logic                 rsp_cout;
    logic                 busy;
    logic [CNTW-1:0]      op_count;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
        .busy(busy), .op_count(op_count)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        req_op[4*i +: 4]    = op;
        req_a[XLEN*i +: XLEN] = a;
        req_b[XLEN*i +: XLEN] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; flush = 1'b0; rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Reference ALU from the opcode definitions, with plain arithmetic.
    function automatic logic [64:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        c;
        int          sh;
        sh = int'(b[5:0]);
        c  = 1'b0;
        r  = '0;
        case (op)
            ALU_ADD:   begin r = a + b; c = (r < a); end
            ALU_SUB:   begin r = a - b; c = (a >= b); end
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_NOR:   r = ~(a | b);
            ALU_XOR:   r = a ^ b;
            ALU_XNOR:  r = ~(a ^ b);
            ALU_NAND:  r = ~(a & b);
            ALU_PASSA: r = a;
            ALU_PASSB: r = b;
            ALU_ZERO:  r = '0;
            ALU_SLT:   r = (a[63] != b[63]) ? 64'(a[63]) : 64'(a < b);
            ALU_SLTU:  r = 64'(a < b);
            ALU_SLL:   r = a << sh;
            ALU_SRL:   r = a >> sh;
            default: begin
                r = a >> sh;
                if (a[63]) for (int k = 0; k < sh; k++) r[63-k] = 1'b1;
            end
        endcase
        return {c, r};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 70));
            2:       return '1;
            default: return 64'(1) << $urandom_range(0, 63);
        endcase
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] data;
        logic        cout;
    } vec_t;

    vec_t tbl[20];

    // Random-phase model state: pending requests and the scheduler's view.
    logic        pv[NREQ];
    logic [3:0]  pop[NREQ];
    logic [63:0] pa[NREQ];
    logic [63:0] pb[NREQ];
    int          m_ptr, m_id, m_id_exec, win;
    bit          m_exec, m_rsp;
    logic [3:0]  m_op;
    logic [63:0] m_a, m_b, m_data;
    logic        m_cout;
    logic [31:0] m_count;
    logic [64:0] ref_res;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{ALU_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'h20,                  64'h8000_0000_0000_001F, 1'b0};
        tbl[1]  = '{ALU_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h0,                   1'b1};
        tbl[2]  = '{ALU_SUB,   64'h5,                   64'h7,                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        tbl[3]  = '{ALU_SUB,   64'h9,                   64'h9,                   64'h0,                   1'b1};
        tbl[4]  = '{ALU_AND,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0};
        tbl[5]  = '{ALU_OR,    64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0};
        tbl[6]  = '{ALU_NOR,   64'h0,                   64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[7]  = '{ALU_XOR,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0};
        tbl[8]  = '{ALU_XNOR,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF00F_F00F_F00F_F00F, 1'b0};
        tbl[9]  = '{ALU_NAND,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FFF_0FFF_0FFF_0FFF, 1'b0};
        tbl[10] = '{ALU_PASSA, 64'h1234_5678_9ABC_DEF0, 64'h55,                  64'h1234_5678_9ABC_DEF0, 1'b0};
        tbl[11] = '{ALU_PASSB, 64'h77,                  64'hDEAD_BEEF,           64'h0000_0000_DEAD_BEEF, 1'b0};
        tbl[12] = '{ALU_ZERO,  64'h1234,                64'h5678,                64'h0,                   1'b0};
        tbl[13] = '{ALU_SLT,   64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h1,                   1'b0};
        tbl[14] = '{ALU_SLTU,  64'h1,                   64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   1'b0};
        tbl[15] = '{ALU_SLTU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h0,                   1'b0};
        tbl[16] = '{ALU_SLL,   64'h1,                   64'd63,                  64'h8000_0000_0000_0000, 1'b0};
        tbl[17] = '{ALU_SRL,   64'h8000_0000_0000_0000, 64'd4,                   64'h0800_0000_0000_0000, 1'b0};
        tbl[18] = '{ALU_SRA,   64'h8000_0000_0000_0000, 64'd4,                   64'hF800_0000_0000_0000, 1'b0};
        tbl[19] = '{ALU_SLL,   64'h1,                   64'h41,                  64'h2,                   1'b0};

        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        flush = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_busy",      64'(busy),      64'h0);
        chk("reset_op_count",  64'(op_count),  64'h0);
        chk("reset_rsp_data",  rsp_data,       64'h0);
        rst = 1'b0;

        // ALU vector table through requester 0.
        for (int k = 0; k < 20; k++) begin
            set_req(0, tbl[k].op, tbl[k].a, tbl[k].b);
            req_valid = 2'b01; rsp_ready = 1'b0;
            #1;
            chk($sformatf("tbl%0d_grant", k), 64'(req_ready), 64'h1);
            tick();
            req_valid = '0;
            chk($sformatf("tbl%0d_exec_busy", k), 64'(busy), 64'h1);
            chk($sformatf("tbl%0d_exec_novalid", k), 64'(rsp_valid), 64'h0);
            tick();
            chk($sformatf("tbl%0d_valid", k), 64'(rsp_valid), 64'h1);
            chk($sformatf("tbl%0d_data", k), rsp_data, tbl[k].data);
            chk($sformatf("tbl%0d_cout", k), 64'(rsp_cout), 64'(tbl[k].cout));
            chk($sformatf("tbl%0d_id", k), 64'(rsp_id), 64'h0);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        chk("tbl_op_count", 64'(op_count), 64'd20);

        // Alternating grants with both requesters always valid.
        do_reset();
        set_req(0, ALU_ADD, 64'd10, 64'd1);
        set_req(1, ALU_SUB, 64'd10, 64'd1);
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_grant", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            chk($sformatf("rr%0d_exec_nogrant", k), 64'(req_ready), 64'h0);
            tick();
            chk($sformatf("rr%0d_id", k), 64'(rsp_id), 64'(k % 2));
            chk($sformatf("rr%0d_data", k), rsp_data, (k % 2 == 0) ? 64'd11 : 64'd9);
        end
        req_valid = '0;
        tick();
        chk("rr_op_count", 64'(op_count), 64'd6);
        chk("rr_idle_busy", 64'(busy), 64'h0);

        // Back-pressure: response held, no grant until rsp_ready.
        set_req(1, ALU_SRA, 64'h8000_0000_0000_0000, 64'd4);
        req_valid = 2'b10; rsp_ready = 1'b0;
        #1;
        chk("bp_grant1", 64'(req_ready), 64'h2);
        tick();
        set_req(0, ALU_ADD, 64'd3, 64'd4);
        set_req(1, ALU_ZERO, 64'h0, 64'h0);
        req_valid = 2'b01;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_nogrant", k), 64'(req_ready), 64'h0);
            chk($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'h1);
            chk($sformatf("bp%0d_data", k), rsp_data, 64'hF800_0000_0000_0000);
            chk($sformatf("bp%0d_id", k), 64'(rsp_id), 64'h1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_b2b_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        chk("bp_b2b_count", 64'(op_count), 64'd7);
        chk("bp_b2b_novalid", 64'(rsp_valid), 64'h0);
        tick();
        chk("bp_b2b_data", rsp_data, 64'd7);
        chk("bp_b2b_id", 64'(rsp_id), 64'h0);
        tick();
        rsp_ready = 1'b0;

        // Flush during EXEC: op dropped, round-robin continues past it.
        req_valid = 2'b11;
        #1;
        chk("fl_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b01; flush = 1'b1;
        #1;
        chk("fl_nogrant", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0;
        chk("fl_novalid", 64'(rsp_valid), 64'h0);
        chk("fl_busy", 64'(busy), 64'h0);
        chk("fl_count", 64'(op_count), 64'd8);
        req_valid = 2'b11;
        #1;
        chk("fl_next_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0; rsp_ready = 1'b1;
        tick();
        chk("fl_next_id", 64'(rsp_id), 64'h0);
        chk("fl_next_data", rsp_data, 64'd7);
        tick();
        chk("fl_next_count", 64'(op_count), 64'd9);
        rsp_ready = 1'b0;

        // Asynchronous reset mid-cycle while a response is pending.
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("ar_pre_valid", 64'(rsp_valid), 64'h1);
        req_valid = 2'b01;
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(rsp_valid), 64'h0);
        chk("ar_data", rsp_data, 64'h0);
        chk("ar_busy", 64'(busy), 64'h0);
        chk("ar_count", 64'(op_count), 64'h0);
        chk("ar_ready", 64'(req_ready), 64'h0);
        #3 rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("ar_first_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0; rsp_ready = 1'b1;
        tick();
        chk("ar_first_id", 64'(rsp_id), 64'h0);
        tick();
        chk("ar_first_count", 64'(op_count), 64'd1);
        rsp_ready = 1'b0;

        // Counter wrap from all-ones, carried by an SLTU op.
        force dut.op_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.op_count_q;
        #1;
        chk("wrap_preload", 64'(op_count), 64'hFFFF_FFFF);
        set_req(0, ALU_SLTU, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        req_valid = 2'b01;
        tick();
        req_valid = '0; rsp_ready = 1'b1;
        tick();
        chk("wrap_sltu", rsp_data, 64'h1);
        tick();
        chk("wrap_count", 64'(op_count), 64'h0);
        rsp_ready = 1'b0;

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_ptr = NREQ - 1; m_exec = 0; m_rsp = 0; m_count = '0;
        m_id = 0; m_id_exec = 0; m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_cout = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i]  = 1'b1;
                    pop[i] = 4'($urandom_range(0, 15));
                    pa[i]  = rnd64();
                    pb[i]  = rnd64();
                end
                req_valid[i] = pv[i];
                set_req(i, pop[i], pa[i], pb[i]);
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            win = -1;
            if (!flush && !m_exec && (!m_rsp || rsp_ready)) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (win < 0 && pv[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                end
            end
            chk("rnd_grant", 64'(req_ready), (win >= 0) ? (64'h1 << win) : 64'h0);
            @(posedge clk);
            if (flush) begin
                m_exec = 0;
                m_rsp  = 0;
            end else begin
                if (m_rsp && rsp_ready) begin
                    m_rsp   = 0;
                    m_count = m_count + 1;
                end
                if (m_exec) begin
                    ref_res = alu_ref(m_op, m_a, m_b);
                    m_data  = ref_res[63:0];
                    m_cout  = ref_res[64];
                    m_id    = m_id_exec;
                    m_rsp   = 1;
                    m_exec  = 0;
                end
                if (win >= 0) begin
                    m_exec    = 1;
                    m_op      = pop[win];
                    m_a       = pa[win];
                    m_b       = pb[win];
                    m_id_exec = win;
                    m_ptr     = win;
                    pv[win]   = 1'b0;
                end
            end
            #1;
            chk("rnd_valid", 64'(rsp_valid), 64'(m_rsp));
            chk("rnd_busy", 64'(busy), 64'(m_exec || m_rsp));
            chk("rnd_count", 64'(op_count), 64'(m_count));
            if (m_rsp) begin
                chk("rnd_data", rsp_data, m_data);
                chk("rnd_cout", 64'(rsp_cout), 64'(m_cout));
                chk("rnd_id", 64'(rsp_id), 64'(m_id));
            end
        end
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
